// File: rtl/dma_arbiter_pkg.sv
// Shared types for the DMA channel arbiter: FSM state encoding and priority mode.
package dma_arbiter_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_GRANT} arbState_t;

  typedef enum logic {PRIO_FIXED = 1'b0, PRIO_ROTATE = 1'b1} prioMode_t;

endpackage

// File: rtl/dma_priority_select.sv
// Combinational winner search: rotate eligible requests by the top pointer,
// take the lowest set bit, then map it back to an absolute channel index.
module dma_priority_select
  import dma_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int CH_W = $clog2(NUM_CHANNELS)
) (
  input  logic [NUM_CHANNELS-1:0] eligible,
  input  logic [CH_W-1:0]         top_ptr,
  input  prioMode_t               mode,
  output logic                    found,
  output logic [CH_W-1:0]         winner
);

  logic [CH_W-1:0]         base;
  logic [NUM_CHANNELS-1:0] rotated;

  always_comb begin
    base    = (mode == PRIO_ROTATE) ? top_ptr : '0;
    rotated = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      rotated[i] = eligible[(i + int'(base)) % NUM_CHANNELS];
    end
    found  = |rotated;
    winner = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (rotated[i]) winner = CH_W'((i + int'(base)) % NUM_CHANNELS);
    end
  end

endmodule

// File: rtl/dma_channel_arbiter.sv
// Registered DMA channel arbiter: raises HRQ on eligible requests, grants one
// channel after HLDA, holds DACK until service ends and then advances rotation.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ARB_IDLE  | no request pending, HRQ low, DACK low
//  ARB_REQ   | HRQ raised, waiting for HLDA (drops back if requests vanish)
//  ARB_GRANT | one channel acknowledged, held until serviceDone or HLDA loss
module dma_channel_arbiter
  import dma_arbiter_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  localparam int CH_W = $clog2(NUM_CHANNELS)
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [NUM_CHANNELS-1:0] DREQ,
  input  logic [NUM_CHANNELS-1:0] reqMask,
  input  logic                    priorityType,
  input  logic                    HLDA,
  input  logic                    serviceDone,
  output logic                    HRQ,
  output logic [NUM_CHANNELS-1:0] DACK,
  output logic                    grantValid,
  output logic [CH_W-1:0]         grantChannel
);

  arbState_t               state, state_next;
  prioMode_t               mode, grant_mode, grant_mode_next;
  logic [NUM_CHANNELS-1:0] eligible, dack_next;
  logic [CH_W-1:0]         top_ptr, top_ptr_next, grant_ch_next, winner;
  logic                    hrq_next, found;

  assign eligible   = DREQ & ~reqMask;
  assign mode       = prioMode_t'(priorityType);
  assign grantValid = |DACK;

  dma_priority_select #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .CH_W         (CH_W)
  ) u_select (
    .eligible (eligible),
    .top_ptr  (top_ptr),
    .mode     (mode),
    .found    (found),
    .winner   (winner)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ARB_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ARB_IDLE:  if (found) state_next = ARB_REQ;
      ARB_REQ: begin
        if (!found)    state_next = ARB_IDLE;
        else if (HLDA) state_next = ARB_GRANT;
      end
      ARB_GRANT: if (serviceDone || !HLDA) state_next = ARB_IDLE;
      default:   state_next = ARB_IDLE;
    endcase
  end

  always_comb begin
    hrq_next        = HRQ;
    dack_next       = DACK;
    grant_ch_next   = grantChannel;
    grant_mode_next = grant_mode;
    top_ptr_next    = top_ptr;
    unique case (state)
      ARB_IDLE: hrq_next = found;
      ARB_REQ: begin
        if (!found) begin
          hrq_next = 1'b0;
        end else if (HLDA) begin
          dack_next       = NUM_CHANNELS'(1) << winner;
          grant_ch_next   = winner;
          grant_mode_next = mode;
        end
      end
      ARB_GRANT: begin
        if (serviceDone || !HLDA) begin
          hrq_next      = 1'b0;
          dack_next     = '0;
          grant_ch_next = '0;
        end
        // Only a completed service rotates; an HLDA abort leaves the pointer alone.
        if (serviceDone && grant_mode == PRIO_ROTATE) begin
          top_ptr_next = (grantChannel == CH_W'(NUM_CHANNELS - 1)) ? '0 : grantChannel + 1'b1;
        end
      end
      default: begin
        hrq_next  = 1'b0;
        dack_next = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      HRQ          <= 1'b0;
      DACK         <= '0;
      grantChannel <= '0;
      grant_mode   <= PRIO_FIXED;
      top_ptr      <= '0;
    end else begin
      HRQ          <= hrq_next;
      DACK         <= dack_next;
      grantChannel <= grant_ch_next;
      grant_mode   <= grant_mode_next;
      top_ptr      <= top_ptr_next;
    end
  end

  a_dack_onehot: assert property (@(posedge CLK) disable iff (RESET) $onehot0(DACK));
  a_dack_hrq:    assert property (@(posedge CLK) disable iff (RESET) (|DACK) |-> HRQ);
  // DACK may outlive HLDA by exactly the one cycle it takes to register the drop.
  a_dack_hlda:   assert property (@(posedge CLK) disable iff (RESET) ((|DACK) && !HLDA) |=> (DACK == '0));
  a_dack_stable: assert property (@(posedge CLK) disable iff (RESET)
                   (state == ARB_GRANT && state_next == ARB_GRANT) |=> $stable(DACK));

endmodule

// File: tb/tb_dma_channel_arbiter.sv
// Self-checking bench for dma_channel_arbiter: expected grants are queued when
// HLDA is driven and compared by a monitor when DACK rises.
module tb_dma_channel_arbiter;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [N-1:0] DREQ = '0;
  logic [N-1:0] reqMask = '0;
  logic         priorityType = 1'b0;
  logic         HLDA = 1'b0;
  logic         serviceDone = 1'b0;
  logic         HRQ;
  logic [N-1:0] DACK;
  logic         grantValid;
  logic [1:0]   grantChannel;

  int           checks = 0;
  int           fails = 0;
  int           exp_q[$];
  int           m_top = 0;
  logic         prev_gv = 1'b0;
  int           mon_e;
  logic [N-1:0] mon_oh;

  dma_channel_arbiter #(.NUM_CHANNELS(N)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DREQ         (DREQ),
    .reqMask      (reqMask),
    .priorityType (priorityType),
    .HLDA         (HLDA),
    .serviceDone  (serviceDone),
    .HRQ          (HRQ),
    .DACK         (DACK),
    .grantValid   (grantValid),
    .grantChannel (grantChannel)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (grantValid && !prev_gv) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_grant: DACK=%b but no grant was expected", DACK);
      end else begin
        mon_e  = exp_q.pop_front();
        mon_oh = '0;
        mon_oh[mon_e] = 1'b1;
        checks++;
        if (DACK !== mon_oh) begin
          fails++;
          $display("FAIL grant_dack: got %b expected %b", DACK, mon_oh);
        end
        checks++;
        if (grantChannel !== mon_e[1:0]) begin
          fails++;
          $display("FAIL grant_channel: got %0d expected %0d", grantChannel, mon_e);
        end
      end
    end
    prev_gv = grantValid;
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic int model_winner(input logic [N-1:0] elig, input bit rot, input int top);
    int c;
    for (int k = 0; k < N; k++) begin
      c = rot ? (top + k) % N : k;
      if (elig[c]) return c;
    end
    return -1;
  endfunction

  task automatic request_and_grant(input int exp_ch, input int hlda_delay, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (HRQ === 1'b1) ok = 1'b1;
      else step();
    end
    if (ok) begin
      repeat (hlda_delay) step();
      HLDA = 1'b1;
      exp_q.push_back(exp_ch);
      step();
    end
  endtask

  task automatic finish_grant(input int ch, input bit rot, input bit drop_hlda);
    serviceDone = 1'b1;
    if (drop_hlda) HLDA = 1'b0;
    step();
    serviceDone = 1'b0;
    HLDA = 1'b0;
    if (rot) m_top = (ch + 1) % N;
  endtask

  task automatic test_reset();
    DREQ = 4'b1111;
    HLDA = 1'b1;
    step();
    step();
    checks++; if (HRQ !== 1'b0) begin fails++; $display("FAIL reset_hrq: got %b expected 0", HRQ); end
    checks++; if (DACK !== 4'b0000) begin fails++; $display("FAIL reset_dack: got %b expected 0000", DACK); end
    checks++; if (grantValid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b expected 0", grantValid); end
    checks++; if (grantChannel !== 2'd0) begin fails++; $display("FAIL reset_channel: got %0d expected 0", grantChannel); end
    RESET = 1'b0;
    DREQ = '0;
    HLDA = 1'b0;
    m_top = 0;
    step();
  endtask

  task automatic test_fixed();
    bit ok;
    int e;
    priorityType = 1'b0;
    DREQ = 4'b1010;
    step();
    checks++; if (HRQ !== 1'b1) begin fails++; $display("FAIL fixed_hrq_latency: got %b expected 1", HRQ); end
    e = model_winner(DREQ & ~reqMask, 1'b0, m_top);
    request_and_grant(e, 2, ok);
    checks++; if (!ok) begin fails++; $display("FAIL fixed_hrq_timeout: HRQ got 0 expected 1"); end
    DREQ = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (DACK !== 4'b0010) begin fails++; $display("FAIL fixed_hold: got %b expected 0010", DACK); end
      step();
    end
    DREQ = '0;
    finish_grant(e, 1'b0, 1'b0);
    checks++; if (DACK !== 4'b0000) begin fails++; $display("FAIL fixed_release: got %b expected 0000", DACK); end
    checks++; if (HRQ !== 1'b0) begin fails++; $display("FAIL fixed_hrq_release: got %b expected 0", HRQ); end
    step();
  endtask

  task automatic test_rotate();
    bit ok;
    int e;
    int seq[5] = '{0, 1, 2, 3, 0};
    priorityType = 1'b1;
    DREQ = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      e = model_winner(DREQ & ~reqMask, 1'b1, m_top);
      request_and_grant(e, 0, ok);
      checks++; if (!ok) begin fails++; $display("FAIL rotate_hrq_timeout: grant %0d HRQ got 0 expected 1", k); end
      checks++;
      if (grantChannel !== seq[k][1:0]) begin
        fails++;
        $display("FAIL rotate_sequence: grant %0d got %0d expected %0d", k, grantChannel, seq[k]);
      end
      step();
      finish_grant(e, 1'b1, 1'b0);
      checks++; if (HRQ !== 1'b0) begin fails++; $display("FAIL rotate_idle_gap: HRQ got %b expected 0", HRQ); end
    end
    DREQ = '0;
    step();
    step();
  endtask

  task automatic test_mask();
    bit ok;
    int e;
    priorityType = 1'b0;
    DREQ = 4'b0011;
    reqMask = 4'b0001;
    e = model_winner(DREQ & ~reqMask, 1'b0, m_top);
    request_and_grant(e, 1, ok);
    checks++; if (!ok) begin fails++; $display("FAIL mask_hrq_timeout: HRQ got 0 expected 1"); end
    reqMask = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (DACK !== 4'b0010) begin fails++; $display("FAIL mask_hold: got %b expected 0010", DACK); end
      step();
    end
    DREQ = '0;
    reqMask = '0;
    finish_grant(e, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_mode_switch();
    bit ok;
    int e;
    priorityType = 1'b1;
    DREQ = 4'b1111;
    step();
    serviceDone = 1'b1;
    step();
    serviceDone = 1'b0;
    checks++; if (HRQ !== 1'b1) begin fails++; $display("FAIL stray_done_hrq: got %b expected 1", HRQ); end
    checks++; if (DACK !== 4'b0000) begin fails++; $display("FAIL stray_done_dack: got %b expected 0000", DACK); end
    e = model_winner(DREQ & ~reqMask, 1'b1, m_top);
    request_and_grant(e, 0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL switch_hrq_timeout: HRQ got 0 expected 1"); end
    checks++; if (grantChannel !== 2'd1) begin fails++; $display("FAIL switch_stored_ptr: got %0d expected 1", grantChannel); end
    DREQ = '0;
    finish_grant(e, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_withdraw();
    priorityType = 1'b0;
    DREQ = 4'b0100;
    step();
    checks++; if (HRQ !== 1'b1) begin fails++; $display("FAIL withdraw_hrq_rise: got %b expected 1", HRQ); end
    DREQ = '0;
    step();
    checks++; if (HRQ !== 1'b0) begin fails++; $display("FAIL withdraw_hrq_fall: got %b expected 0", HRQ); end
    HLDA = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (DACK !== 4'b0000 || HRQ !== 1'b0) begin
        fails++;
        $display("FAIL idle_hlda_ignored: DACK=%b HRQ=%b expected 0000/0", DACK, HRQ);
      end
    end
    HLDA = 1'b0;
    step();
  endtask

  task automatic test_abort();
    bit ok;
    int e;
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    m_top = 0;
    step();
    priorityType = 1'b1;
    DREQ = 4'b0100;
    e = model_winner(DREQ & ~reqMask, 1'b1, m_top);
    request_and_grant(e, 0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL abort_hrq_timeout: HRQ got 0 expected 1"); end
    checks++; if (grantChannel !== 2'd2) begin fails++; $display("FAIL abort_grant: got %0d expected 2", grantChannel); end
    HLDA = 1'b0;
    DREQ = 4'b1111;
    step();
    checks++; if (DACK !== 4'b0000) begin fails++; $display("FAIL abort_dack: got %b expected 0000", DACK); end
    checks++; if (HRQ !== 1'b0) begin fails++; $display("FAIL abort_hrq: got %b expected 0", HRQ); end
    e = model_winner(DREQ & ~reqMask, 1'b1, m_top);
    request_and_grant(e, 0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL abort_regrant_timeout: HRQ got 0 expected 1"); end
    checks++; if (grantChannel !== 2'd0) begin fails++; $display("FAIL abort_ptr_kept: got %0d expected 0", grantChannel); end
    DREQ = '0;
    finish_grant(e, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_done_with_hlda_drop();
    bit ok;
    int e;
    priorityType = 1'b1;
    DREQ = 4'b1111;
    e = model_winner(DREQ & ~reqMask, 1'b1, m_top);
    request_and_grant(e, 0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL drop_hrq_timeout: HRQ got 0 expected 1"); end
    finish_grant(e, 1'b1, 1'b1);
    checks++; if (DACK !== 4'b0000) begin fails++; $display("FAIL drop_dack: got %b expected 0000", DACK); end
    e = model_winner(DREQ & ~reqMask, 1'b1, m_top);
    request_and_grant(e, 0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL drop_regrant_timeout: HRQ got 0 expected 1"); end
    checks++; if (grantChannel !== 2'd2) begin fails++; $display("FAIL drop_rotation: got %0d expected 2", grantChannel); end
    DREQ = '0;
    finish_grant(e, 1'b1, 1'b0);
    step();
  endtask

  task automatic test_reset_mid_grant();
    bit ok;
    int e;
    priorityType = 1'b0;
    DREQ = 4'b1000;
    e = model_winner(DREQ & ~reqMask, 1'b0, m_top);
    request_and_grant(e, 0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rst_hrq_timeout: HRQ got 0 expected 1"); end
    step();
    #2;
    RESET = 1'b1;
    #1;
    checks++; if (DACK !== 4'b0000) begin fails++; $display("FAIL rst_async_dack: got %b expected 0000", DACK); end
    checks++; if (HRQ !== 1'b0) begin fails++; $display("FAIL rst_async_hrq: got %b expected 0", HRQ); end
    checks++; if (grantValid !== 1'b0) begin fails++; $display("FAIL rst_async_valid: got %b expected 0", grantValid); end
    m_top = 0;
    step();
    RESET = 1'b0;
    HLDA = 1'b0;
    priorityType = 1'b1;
    DREQ = 4'b1111;
    e = model_winner(DREQ & ~reqMask, 1'b1, m_top);
    request_and_grant(e, 0, ok);
    checks++; if (!ok) begin fails++; $display("FAIL rst_regrant_timeout: HRQ got 0 expected 1"); end
    checks++; if (grantChannel !== 2'd0) begin fails++; $display("FAIL rst_ptr_cleared: got %0d expected 0", grantChannel); end
    DREQ = '0;
    finish_grant(e, 1'b1, 1'b0);
    step();
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_rotate();
    test_mask();
    test_mode_switch();
    test_withdraw();
    test_abort();
    test_done_with_hlda_drop();
    test_reset_mid_grant();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL missing_grants: %0d queued grants never observed, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
